// File: rtl/dsc_pkg.sv
// Shared constants, state encoding and operand payload for the dsc_mul_seq sequencer and its dsc_mul core.
// The optional DSC_SEQ_CYCLE_CNT_EN build macro (used by the interface and top) exposes the RUN-cycle count.
package dsc_pkg;

  localparam int unsigned SNG_WIDTH      = 4;
  localparam int unsigned NUM_INPUTS     = 3;
  localparam int unsigned Z_WIDTH        = NUM_INPUTS * SNG_WIDTH;
  localparam int unsigned MAX_CYCLES     = 4100;
  localparam int unsigned CNT_WIDTH      = 13;
  localparam int unsigned CORE_CNT_WIDTH = NUM_INPUTS * SNG_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    HOLD
  } dsc_seq_state_t;

  typedef logic [SNG_WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
    operand_t c;
  } operand_triple_t;

  // Deterministic stream bit: 1 while the stream index is below the operand value.
  function automatic logic sng_bit(input operand_t idx, input operand_t val);
    return idx < val;
  endfunction

endpackage

// File: rtl/dsc_mul_seq_if.sv
// Operand/result valid-ready bus of dsc_mul_seq; out_cyc exists only with DSC_SEQ_CYCLE_CNT_EN.
interface dsc_mul_seq_if;
  import dsc_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  operand_t             in_a;
  operand_t             in_b;
  operand_t             in_c;
  logic                 out_valid;
  logic                 out_ready;
  logic [Z_WIDTH-1:0]   out_z;
  logic                 out_tmo;
`ifdef DSC_SEQ_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] out_cyc;
`endif

  // Operand source and result sink side
  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_c,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_z,
`ifdef DSC_SEQ_CYCLE_CNT_EN
    input  out_cyc,
`endif
    input  out_tmo
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_c,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_z,
`ifdef DSC_SEQ_CYCLE_CNT_EN
    output out_cyc,
`endif
    output out_tmo
  );

endinterface

// File: rtl/dsc_mul.sv
// 3-input 4b deterministic stochastic multiplier: nested-digit counter streams, AND-ed and counted into z.
// o_ov_c flags that no further stream ones can occur, so the run may stop early.
module dsc_mul
  import dsc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  operand_triple_t    i_ops,
  output logic [Z_WIDTH-1:0] o_z,
  output logic               o_ov_c
);

  localparam int unsigned DIG_A = 0;
  localparam int unsigned DIG_B = SNG_WIDTH;
  localparam int unsigned DIG_C = 2 * SNG_WIDTH;

  logic [CORE_CNT_WIDTH-1:0] r_cnt;
  logic [Z_WIDTH-1:0]        r_z;
  logic                      w_bit;

  // Each digit of the counter indexes one stream; c's digit is slowest, so once it passes c we are done.
  always_comb begin
    w_bit  = sng_bit(r_cnt[DIG_A +: SNG_WIDTH], i_ops.a)
           & sng_bit(r_cnt[DIG_B +: SNG_WIDTH], i_ops.b)
           & sng_bit(r_cnt[DIG_C +: SNG_WIDTH], i_ops.c);
    o_ov_c = (i_ops.a == '0) | (i_ops.b == '0)
           | (r_cnt[DIG_C +: SNG_WIDTH] >= i_ops.c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_z   <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CORE_CNT_WIDTH'(1);
      r_z   <= r_z + Z_WIDTH'(w_bit);
    end
  end

  assign o_z = r_z;

endmodule

// File: rtl/dsc_mul_seq.sv
// Transaction sequencer around dsc_mul: accept triple, clear core, run to ov or timeout, return product.
// Build macro DSC_SEQ_CYCLE_CNT_EN adds the out_cyc RUN-cycle count to the result.
module dsc_mul_seq
  import dsc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  dsc_mul_seq_if.slave bus
);

  dsc_seq_state_t       r_state;
  operand_triple_t      r_ops;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_tmo;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [Z_WIDTH-1:0]   r_out_z;
  logic                 r_out_tmo;
`ifdef DSC_SEQ_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] r_out_cyc;
`endif

  logic                 w_core_rst;
  logic                 w_core_en;
  logic [Z_WIDTH-1:0]   w_z;
  logic                 w_ov;
  logic                 w_accept;
  logic                 w_timeout;

  // A top-level reset always clears the core as well.
  assign w_core_rst = rst | (r_state == CLEAR);
  assign w_core_en  = (r_state == RUN);
  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_timeout  = (r_cnt == CNT_WIDTH'(MAX_CYCLES - 1));

  dsc_mul u_core (
    .clk    (clk),
    .rst    (w_core_rst),
    .i_en   (w_core_en),
    .i_ops  (r_ops),
    .o_z    (w_z),
    .o_ov_c (w_ov)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ops       <= '0;
      r_cnt       <= '0;
      r_tmo       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_tmo   <= 1'b0;
`ifdef DSC_SEQ_CYCLE_CNT_EN
      r_out_cyc   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_ops      <= '{a: bus.in_a, b: bus.in_b, c: bus.in_c};
            r_in_ready <= 1'b0;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          r_cnt   <= '0;
          r_tmo   <= 1'b0;
          r_state <= RUN;
        end
        RUN: begin
          // ov takes priority over a coincident timeout.
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (w_ov) begin
            r_tmo   <= 1'b0;
            r_state <= DRAIN;
          end else if (w_timeout) begin
            r_tmo   <= 1'b1;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_out_z     <= w_z;
          r_out_tmo   <= r_tmo;
`ifdef DSC_SEQ_CYCLE_CNT_EN
          r_out_cyc   <= r_cnt;
`endif
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;
  assign bus.out_tmo   = r_out_tmo;
`ifdef DSC_SEQ_CYCLE_CNT_EN
  assign bus.out_cyc   = r_out_cyc;
`endif

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Scoreboard bench for dsc_mul_seq: directed triples push expectations, a negedge monitor checks results.
module tb_dsc_mul_seq;
  import dsc_pkg::*;

  typedef struct {
    int z;
    int tmo;
    int cyc;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;
  exp_t exp_q[$];

  dsc_mul_seq_if bus ();

  dsc_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: stability while held, full compare on the handshake cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !prev_v) rise_cyc = cyc_n;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else if (!bus.out_ready) begin
          if (exp_q[0].z >= 0) chk("hold_z", int'(bus.out_z), exp_q[0].z);
          chk("hold_tmo", int'(bus.out_tmo), exp_q[0].tmo);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.z >= 0) chk("out_z", int'(bus.out_z), e.z);
          chk("out_tmo", int'(bus.out_tmo), e.tmo);
`ifdef DSC_SEQ_CYCLE_CNT_EN
          if (e.cyc >= 0) chk("out_cyc", int'(bus.out_cyc), e.cyc);
`endif
          if (e.lat >= 0) chk("latency", rise_cyc - e.acc, e.lat);
          else chk("latency_bound", int'((rise_cyc - e.acc) <= 4098), 1);
        end
      end
    end
    prev_v = bus.out_valid;
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input int z, input int tmo, input int cyc, input int lat, input bit push);
    int n = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    while (!bus.in_ready && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e = '{z: z, tmo: tmo, cyc: cyc, lat: lat, acc: cyc_n};
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_bad;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_z", int'(bus.out_z), 0);
    chk("rst_out_tmo", int'(bus.out_tmo), 0);
`ifdef DSC_SEQ_CYCLE_CNT_EN
    chk("rst_out_cyc", int'(bus.out_cyc), 0);
`endif
    rst = 1'b0;

    // Full-scale product, early stop by ov
    send(4'd15, 4'd15, 4'd15, 3375, 0, -1, -1, 1'b1);
    wait_drain(6000);

    // Busy source, then back-to-back second triple
    send(4'd3, 4'd5, 4'd7, 105, 0, -1, -1, 1'b1);
    busy_bad = 0;
    n = 0;
    while (!bus.out_valid && n < 6000) begin
      if (bus.in_ready) busy_bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_busy", busy_bad, 0);
    send(4'd1, 4'd1, 4'd1, 1, 0, -1, -1, 1'b1);
    wait_drain(6000);

    // c=0 stops in the first RUN cycle
    send(4'd9, 4'd9, 4'd0, 0, 0, 1, 3, 1'b1);
    wait_drain(100);

    // Result held with sink stalled; in_valid during HOLD must be ignored
    bus.out_ready = 1'b0;
    send(4'd6, 4'd7, 4'd2, 84, 0, -1, -1, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_a = 4'd4;
    bus.in_b = 4'd4;
    bus.in_c = 4'd4;
    busy_bad = 0;
    repeat (20) begin
      if (bus.in_ready) busy_bad++;
      @(posedge clk); #1;
    end
    chk("hold_in_ready", busy_bad, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", int'(bus.in_ready), 1);
    chk("valid_after_release", int'(bus.out_valid), 0);
    chk("queue_after_release", exp_q.size(), 0);

    // Reset mid-RUN discards the transaction
    send(4'd15, 4'd15, 4'd15, 0, 0, -1, -1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(bus.in_ready), 1);
    busy_bad = 0;
    repeat (4200) begin
      if (bus.out_valid) busy_bad++;
      @(posedge clk); #1;
    end
    chk("no_valid_after_rst", busy_bad, 0);
    send(4'd2, 4'd2, 4'd2, 8, 0, -1, -1, 1'b1);
    wait_drain(6000);

    // Suppressed ov forces the timeout path
    force dut.w_ov = 1'b0;
    send(4'd15, 4'd15, 4'd15, -1, 1, 4100, 4102, 1'b1);
    wait_drain(6000);
    release dut.w_ov;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
